ipv4_hdr_gen: RTL and testbench

Parametrised IPv4 header generator that builds a complete 20-byte header per packet into the TX header buffer, W_BYTES bytes per write beat. Holds programmable source/destination IP, TTL and protocol. Keeps the static checksum partial sum precomputed so each header needs only the length and ID additions. Sits between the packet-length source (UDP/payload framer) and the header RAM feeding the MAC TX path.

---
 rtl/ipv4_hdr_pkg.sv | 48 ++++
 rtl/ipv4_hdr_gen_ones_add16.sv | 14 +
 rtl/ipv4_hdr_gen.sv | 183 ++++++++++++++++++
 tb/tb_ipv4_hdr_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_hdr_pkg.sv
// Shared constants, FSM state type and reset-checksum helper for the
// IPv4 header generator.
package ipv4_hdr_pkg;

  localparam int HDR_LEN      = 20;
  localparam int MAX_DATA_LEN = 65515;

  localparam logic [7:0]  VER_IHL    = 8'h45;
  localparam logic [15:0] FLAGS_FRAG = 16'h4000;

  localparam int OFF_VER   = 0;
  localparam int OFF_TOS   = 1;
  localparam int OFF_LEN   = 2;
  localparam int OFF_ID    = 4;
  localparam int OFF_FLAGS = 6;
  localparam int OFF_TTL   = 8;
  localparam int OFF_PROTO = 9;
  localparam int OFF_CSUM  = 10;
  localparam int OFF_SRC   = 12;
  localparam int OFF_DST   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG1,
    S_CFG2,
    S_SUM1,
    S_SUM2,
    S_EMIT,
    S_DONE
  } state_e;

  function automatic logic [16:0] static_sum_init(
    input logic [31:0] src,
    input logic [31:0] dst,
    input logic [7:0]  ttl,
    input logic [7:0]  proto
  );
    logic [31:0] s;
    s = {16'h0, VER_IHL, 8'h00} + {16'h0, FLAGS_FRAG}
      + {16'h0, ttl, proto}
      + {16'h0, src[31:16]} + {16'h0, src[15:0]}
      + {16'h0, dst[31:16]} + {16'h0, dst[15:0]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return {1'b0, s[15:0]};
  endfunction

endpackage

// File: rtl/ipv4_hdr_gen_ones_add16.sv
// 16-bit one's-complement adder with end-around carry.
// A single re-add suffices: a+b <= 0x1FFFE folds to at most 0xFFFF.
module ones_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [16:0] s;

  assign s = {1'b0, a} + {1'b0, b};
  assign y = s[15:0] + {15'h0, s[16]};

endmodule

// File: rtl/ipv4_hdr_gen.sv
// IPv4 header generator: builds a 20-byte header per start and writes
// it W_BYTES per beat into the TX header buffer.
module ipv4_hdr_gen
  import ipv4_hdr_pkg::*;
#(
  parameter int          W_BYTES    = 1,
  parameter logic [31:0] INIT_SRCIP = 32'hC0A80105,
  parameter logic [31:0] INIT_DSTIP = 32'hFFFFFFFF,
  parameter logic [7:0]  INIT_TTL   = 8'h40,
  parameter logic [7:0]  INIT_PROTO = 8'h11
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [15:0]          i_data_length,
  input  logic                 i_cfg_wr,
  input  logic [1:0]           i_cfg_sel,
  input  logic [31:0]          i_cfg_data,
  output logic                 o_ready,
  output logic                 o_wr_en,
  output logic [4:0]           o_wr_addr,
  output logic [8*W_BYTES-1:0] o_wr_data,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int DW     = 8 * W_BYTES;
  localparam int NBEATS = HDR_LEN / W_BYTES;
  localparam int HB     = 8 * HDR_LEN;

  localparam logic [16:0] STATIC_INIT =
    static_sum_init(INIT_SRCIP, INIT_DSTIP, INIT_TTL, INIT_PROTO);

  state_e      state_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [7:0]  ttl_q;
  logic [7:0]  proto_q;
  logic [16:0] static_q;
  logic [15:0] id_q;
  logic [15:0] len_q;
  logic [15:0] tot_q;
  logic [15:0] sum1_q;
  logic [15:0] csum_q;
  logic        err_q;
  logic        hdr_q;
  logic [1:0]  sel_q;
  logic [31:0] cfg_q;
  logic [4:0]  beat_q;
  logic [4:0]  addr_q;
  logic [DW-1:0] data_q;

  logic [15:0] static_f;
  logic [15:0] tot_len;
  logic        ovf;
  logic [15:0] sum_len;
  logic [15:0] sum_id;
  logic [15:0] st1, st2, st3, st4, st5, st6;
  logic [HB-1:0] hdr_vec;
  logic [HB-1:0] hdr_sh;
  logic [4:0]    nxt_addr;
  logic [DW-1:0] beat_data;

  // static_q is kept folded; the extra fold only guards a stray carry
  assign static_f = static_q[15:0] + {15'h0, static_q[16]};
  assign tot_len  = len_q + 16'(HDR_LEN);
  assign ovf      = len_q > 16'(MAX_DATA_LEN);

  ones_add16 u_len (.a(static_f), .b(tot_len), .y(sum_len));
  ones_add16 u_id  (.a(sum1_q),   .b(id_q),    .y(sum_id));

  ones_add16 u_st1 (
    .a({VER_IHL, 8'h00}), .b(FLAGS_FRAG), .y(st1)
  );
  ones_add16 u_st2 (.a(st1), .b({ttl_q, proto_q}), .y(st2));
  ones_add16 u_st3 (.a(st2), .b(src_q[31:16]),     .y(st3));
  ones_add16 u_st4 (.a(st3), .b(src_q[15:0]),      .y(st4));
  ones_add16 u_st5 (.a(st4), .b(dst_q[31:16]),     .y(st5));
  ones_add16 u_st6 (.a(st5), .b(dst_q[15:0]),      .y(st6));

  assign hdr_vec = {
    VER_IHL, 8'h00, tot_q, id_q, FLAGS_FRAG,
    ttl_q, proto_q, csum_q, src_q, dst_q
  };

  // Slice for the beat about to be presented on the write port
  assign nxt_addr  = (state_q == S_EMIT) ?
                     addr_q + 5'(W_BYTES) : 5'd0;
  assign hdr_sh    = hdr_vec << {nxt_addr, 3'b000};
  assign beat_data = hdr_sh[HB-1 -: DW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= INIT_SRCIP;
      dst_q    <= INIT_DSTIP;
      ttl_q    <= INIT_TTL;
      proto_q  <= INIT_PROTO;
      static_q <= STATIC_INIT;
      id_q     <= 16'h0;
      len_q    <= 16'h0;
      tot_q    <= 16'h0;
      sum1_q   <= 16'h0;
      csum_q   <= 16'h0;
      err_q    <= 1'b0;
      hdr_q    <= 1'b0;
      sel_q    <= 2'd0;
      cfg_q    <= 32'h0;
      beat_q   <= 5'd0;
      addr_q   <= 5'd0;
      data_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_cfg_wr) begin
            sel_q   <= i_cfg_sel;
            cfg_q   <= i_cfg_data;
            state_q <= S_CFG1;
          end else if (i_start) begin
            len_q   <= i_data_length;
            state_q <= S_SUM1;
          end
        end
        S_CFG1: begin
          unique case (sel_q)
            2'd0:    src_q <= cfg_q;
            2'd1:    dst_q <= cfg_q;
            2'd2:    {ttl_q, proto_q} <= cfg_q[15:0];
            default: ;
          endcase
          err_q   <= 1'b0;
          hdr_q   <= 1'b0;
          state_q <= S_CFG2;
        end
        S_CFG2: begin
          static_q <= {1'b0, st6};
          state_q  <= S_DONE;
        end
        S_SUM1: begin
          sum1_q  <= sum_len;
          tot_q   <= tot_len;
          err_q   <= ovf;
          hdr_q   <= 1'b1;
          state_q <= S_SUM2;
        end
        S_SUM2: begin
          csum_q <= ~sum_id;
          if (err_q) begin
            state_q <= S_DONE;
          end else begin
            beat_q  <= 5'd0;
            addr_q  <= 5'd0;
            data_q  <= beat_data;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (beat_q == 5'(NBEATS - 1)) begin
            state_q <= S_DONE;
          end else begin
            beat_q <= beat_q + 5'd1;
            addr_q <= nxt_addr;
            data_q <= beat_data;
          end
        end
        S_DONE: begin
          if (hdr_q && !err_q)
            id_q <= id_q + 16'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_wr_en   = (state_q == S_EMIT);
  assign o_wr_addr = addr_q;
  assign o_wr_data = data_q;
  assign o_done    = (state_q == S_DONE);
  assign o_err     = o_done & err_q;

endmodule

// File: tb/tb_ipv4_hdr_gen.sv
// Self-checking bench: W=1 and W=4 instances driven in lockstep and
// compared against a byte-level IPv4 header model.
module tb_ipv4_hdr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dlen;
  logic        cfg_wr;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;

  logic        r1, we1, d1, e1;
  logic [4:0]  wa1;
  logic [7:0]  wd1;
  logic        r4, we4, d4, e4;
  logic [4:0]  wa4;
  logic [31:0] wd4;

  always #5 clk = ~clk;

  ipv4_hdr_gen #(.W_BYTES(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_data_length(dlen), .i_cfg_wr(cfg_wr),
    .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .o_ready(r1), .o_wr_en(we1), .o_wr_addr(wa1),
    .o_wr_data(wd1), .o_done(d1), .o_err(e1)
  );

  ipv4_hdr_gen #(.W_BYTES(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_data_length(dlen), .i_cfg_wr(cfg_wr),
    .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .o_ready(r4), .o_wr_en(we4), .o_wr_addr(wa4),
    .o_wr_data(wd4), .o_done(d4), .o_err(e4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // write/done monitors, sampled on the falling edge
  int nwr1, ndone1, tdone1, abad1;
  int nwr4, ndone4, tdone4, abad4;
  bit err1, err4;
  logic [7:0] buf1 [20];
  logic [7:0] buf4 [20];

  always @(negedge clk) begin
    if (we1) begin
      if (wa1 != 5'(nwr1)) abad1++;
      if (wa1 < 5'd20) buf1[wa1] = wd1;
      nwr1++;
    end
    if (d1) begin
      ndone1++;
      tdone1 = cyc;
      err1 = e1;
    end
  end

  always @(negedge clk) begin
    if (we4) begin
      if (wa4 != 5'(nwr4 * 4)) abad4++;
      for (int l = 0; l < 4; l++)
        if (int'(wa4) + l < 20) buf4[int'(wa4) + l] = wd4[31-8*l -: 8];
      nwr4++;
    end
    if (d4) begin
      ndone4++;
      tdone4 = cyc;
      err4 = e4;
    end
  end

  // reference model
  logic [31:0] m_src, m_dst;
  logic [7:0]  m_ttl, m_proto;
  logic [15:0] m_id;
  logic [7:0]  exp_b [20];

  task automatic model_reset();
    m_src = 32'hC0A80105;
    m_dst = 32'hFFFFFFFF;
    m_ttl = 8'h40;
    m_proto = 8'h11;
    m_id = 16'h0;
  endtask

  function automatic void model_hdr(input logic [15:0] len);
    logic [15:0] w [10];
    int s;
    w = '{16'h4500, len + 16'd20, m_id, 16'h4000, {m_ttl, m_proto},
          16'h0, m_src[31:16], m_src[15:0], m_dst[31:16], m_dst[15:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    w[5] = ~s[15:0];
    for (int i = 0; i < 10; i++) begin
      exp_b[2*i]   = w[i][15:8];
      exp_b[2*i+1] = w[i][7:0];
    end
  endfunction

  task automatic clr_mon();
    nwr1 = 0; abad1 = 0; nwr4 = 0; abad4 = 0;
    for (int i = 0; i < 20; i++) begin
      buf1[i] = 8'h00;
      buf4[i] = 8'h00;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(r1 && r4) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_timeout", 32'(k < 100), 32'd1);
  endtask

  // One operation; inj>0 re-pulses start inj cycles after acceptance.
  task automatic run_op(input bit st, input bit cw,
                        input logic [1:0] sel, input logic [31:0] d,
                        input logic [15:0] l, input int inj);
    int b1, b4, k, tacc, lat1, lat4, n1, n4;
    bit hdr, ovf;
    wait_ready();
    clr_mon();
    b1 = ndone1;
    b4 = ndone4;
    hdr = st && !cw;
    ovf = hdr && (l > 16'd65515);
    start = st; cfg_wr = cw; cfg_sel = sel; cfg_data = d; dlen = l;
    tacc = cyc;
    @(posedge clk); #1;
    start = 1'b0; cfg_wr = 1'b0;
    k = 0;
    while (!(ndone1 > b1 && ndone4 > b4) && k < 60) begin
      if (inj > 0 && k == inj) start = 1'b1;
      if (inj > 0 && k == inj + 2) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("done_timeout", 32'(k < 60), 32'd1);
    if (cw) begin
      unique case (sel)
        2'd0: m_src = d;
        2'd1: m_dst = d;
        2'd2: {m_ttl, m_proto} = d[15:0];
        default: ;
      endcase
    end
    if (hdr && !ovf) model_hdr(l);
    lat1 = (hdr && !ovf) ? 23 : 3;
    lat4 = (hdr && !ovf) ? 8 : 3;
    n1 = (hdr && !ovf) ? 20 : 0;
    n4 = (hdr && !ovf) ? 5 : 0;
    chk("w1_done_time", 32'(tdone1 - tacc), 32'(lat1));
    chk("w4_done_time", 32'(tdone4 - tacc), 32'(lat4));
    chk("w1_err", 32'(err1), 32'(ovf));
    chk("w4_err", 32'(err4), 32'(ovf));
    chk("w1_nwr", 32'(nwr1), 32'(n1));
    chk("w4_nwr", 32'(nwr4), 32'(n4));
    chk("w1_addr_seq", 32'(abad1), 32'd0);
    chk("w4_addr_seq", 32'(abad4), 32'd0);
    if (hdr && !ovf) begin
      for (int i = 0; i < 20; i++) begin
        chk($sformatf("w1_byte%0d", i), 32'(buf1[i]), 32'(exp_b[i]));
        chk($sformatf("w4_byte%0d", i), 32'(buf4[i]), 32'(exp_b[i]));
      end
      m_id = m_id + 16'd1;
    end
  endtask

  typedef struct {
    logic [15:0] len;
    logic [15:0] tot;
    logic [15:0] csum;
    logic [15:0] id;
    bit          err;
  } vec_t;

  vec_t vt [5];

  initial begin
    int base, tacc;
    logic [15:0] rl;

    vt[0] = '{16'd8,     16'h001C, 16'h7924, 16'h0000, 1'b0};
    vt[1] = '{16'd8,     16'h001C, 16'h7923, 16'h0001, 1'b0};
    vt[2] = '{16'd65516, 16'h0000, 16'h0000, 16'h0002, 1'b1};
    vt[3] = '{16'd65515, 16'hFFFF, 16'h793E, 16'h0002, 1'b0};
    vt[4] = '{16'd0,     16'h0014, 16'h7929, 16'h0003, 1'b0};

    rst_n = 1'b0; start = 1'b0; cfg_wr = 1'b0;
    cfg_sel = 2'd0; cfg_data = 32'h0; dlen = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready1", 32'(r1), 32'd1);
    chk("rst_ready4", 32'(r4), 32'd1);
    chk("rst_wr_en", 32'({we1, we4}), 32'd0);
    chk("rst_done_err", 32'({d1, d4, e1, e4}), 32'd0);
    chk("rst_addr", 32'({wa1, wa4}), 32'd0);
    chk("rst_data1", 32'(wd1), 32'd0);
    chk("rst_data4", wd4, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, 1'b0, 2'd0, 32'h0, vt[i].len, 0);
      if (!vt[i].err) begin
        chk($sformatf("vec%0d_tot", i), 32'({buf1[2], buf1[3]}),
            32'(vt[i].tot));
        chk($sformatf("vec%0d_id", i), 32'({buf1[4], buf1[5]}),
            32'(vt[i].id));
        chk($sformatf("vec%0d_csum1", i), 32'({buf1[10], buf1[11]}),
            32'(vt[i].csum));
        chk($sformatf("vec%0d_csum4", i), 32'({buf4[10], buf4[11]}),
            32'(vt[i].csum));
      end
    end

    // dst IP config, then header uses it
    run_op(1'b0, 1'b1, 2'd1, 32'hC0A80101, 16'h0, 0);
    run_op(1'b1, 1'b0, 2'd0, 32'h0, 16'd8, 0);
    chk("cfg_dst_bytes", {buf1[16], buf1[17], buf1[18], buf1[19]},
        32'hC0A80101);

    // start+cfg together: config wins, start dropped
    base = ndone1;
    run_op(1'b1, 1'b1, 2'd2, 32'h00002006, 16'd8, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("simul_no_hdr", 32'(ndone1 - base), 32'd1);
    run_op(1'b1, 1'b0, 2'd0, 32'h0, 16'd100, 0);
    chk("ttl_proto", 32'({buf4[8], buf4[9]}), 32'h2006);

    run_op(1'b0, 1'b1, 2'd3, 32'hDEADBEEF, 16'h0, 0);

    // start during EMIT ignored
    base = ndone1;
    run_op(1'b1, 1'b0, 2'd0, 32'h0, 16'd30, 4);
    repeat (30) @(posedge clk);
    #1;
    chk("busy_start_ignored", 32'(ndone1 - base), 32'd1);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_op(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom, 16'h0, 0);
      end else begin
        rl = ($urandom_range(0, 4) == 0) ?
             16'(65510 + $urandom_range(0, 25)) : 16'($urandom);
        run_op(1'b1, 1'b0, 2'd0, 32'h0, rl, 0);
      end
    end

    // reset mid-EMIT
    wait_ready();
    clr_mon();
    start = 1'b1; dlen = 16'd8;
    tacc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < tacc + 6) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_wr_en", 32'({we1, we4}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'({we1, we4}), 32'd0);
    chk("mid_rst_ready", 32'({r1, r4}), 32'b11);
    chk("mid_rst_done", 32'({d1, d4}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 2'd0, 32'h0, 16'd8, 0);
    chk("post_rst_id", 32'({buf1[4], buf1[5]}), 32'h0);
    chk("post_rst_csum", 32'({buf4[10], buf4[11]}), 32'h7924);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
